param_lifo_stack: RTL and testbench
===================================

Name: param_lifo_stack

Overview:
- Parametrised LIFO stack built on a 1-write/1-read register file: flip-flop storage, write decode and read mux.
- Generalises the fixed 8x8 register file: configurable data width and depth, plus an internal stack pointer.
- Adds push/pop handshake, full/empty/count status, a registered pop-data output and sticky overflow/underflow error flags.
- Used as the operand/return stack in the stack datapath.

Parameters:
DWIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2, power of two not required)
AWIDTH, 3, pointer width; must equal ceil(log2(DEPTH)); elaboration error otherwise

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
push  input  1  write din onto top of stack this cycle
pop  input  1  remove top entry this cycle
din  input  DWIDTH  push data
clr_err  input  1  clears ovf and udf
dout  output  DWIDTH  registered popped data
dout_valid  output  1  one-cycle strobe: dout updated this cycle
top  output  DWIDTH  combinational peek of current top entry; 0 when empty
count  output  AWIDTH+1  number of valid entries, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
ovf  output  1  sticky: push attempted while full
udf  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, dout=0, dout_valid=0, ovf=0, udf=0; therefore empty=1, full=0, top=0.
  - Storage array is not reset; its contents are don't-care.
- count is the stack pointer: next write slot = count, top entry = mem[count-1].
- All updates occur on the rising clk edge. empty, full and top are combinational from count/mem.
- dout_valid defaults to 0 every cycle unless set by a case below.
- push=1, pop=0:
  - If !full: mem[count]<=din, count+1.
  - If full: no write, count unchanged, ovf<=1.
- push=0, pop=1:
  - If !empty: dout<=mem[count-1], dout_valid<=1, count-1.
  - If empty: dout holds, dout_valid=0, udf<=1.
- push=1, pop=1 (replace):
  - If !empty, including full: dout<=mem[count-1], dout_valid<=1, mem[count-1]<=din, count unchanged. No ovf.
  - If empty (bypass): dout<=din, dout_valid<=1, count stays 0, storage untouched. No udf.
- Latency:
  - Pushed data is visible on top the cycle after the push edge.
  - Popped data is on dout with dout_valid high for exactly one cycle after the pop edge.
- Sticky flags:
  - ovf/udf remain set until clr_err=1 or reset.
  - If clr_err and a new error event occur in the same cycle, set wins (flag stays 1).
- Pointer arithmetic:
  - count never exceeds DEPTH and never goes below 0; there is no wrap-around.
  - Non-power-of-two DEPTH (e.g. 6) must still report full at count==DEPTH.
- Reset asserted mid-operation empties the stack immediately. The first push after deassertion writes mem[0].
- din is sampled only when a push takes effect. Storage is otherwise never written.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on consecutive cycles -> count=3, top=0x33. Three pops -> dout 0x33,0x22,0x11, each with a 1-cycle dout_valid. Then empty=1, top=0.
- DEPTH=8: push 0x00..0x07 -> full=1, count=8. Push 0xAA -> ovf=1, count=8. Pop -> dout=0x07, not 0xAA.
- Empty stack: pop -> udf=1, dout_valid=0, dout unchanged. clr_err -> udf=0. Pop with clr_err in the same cycle -> udf=1.
- Stack holding 0x5A: push+pop with din=0xC3 -> dout=0x5A, dout_valid=1, count=1, top=0xC3. On empty: push+pop din=0x99 -> dout=0x99, count=0.
- DWIDTH=16, DEPTH=6, AWIDTH=3: push 6 values -> full at count=6. 7th push -> ovf. Pop all -> LIFO order, empty.
- After 4 pushes, assert rst_n low between clock edges -> count=0, empty=1, dout=0 immediately. After release, push 0x77 -> top=0x77, count=1.

Source files
------------

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack: flip-flop register file with write decode and read mux,
// internal stack pointer, push/pop/replace handshake, registered pop data, sticky errors.
module param_lifo_stack #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8,
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  input  logic              clr_err,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid,
  output logic [DWIDTH-1:0] top,
  output logic [AWIDTH:0]   count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              udf
);

  localparam int CW = AWIDTH + 1;
  localparam logic [AWIDTH:0] depth_c = CW'(DEPTH);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("param_lifo_stack: DEPTH must be at least 2");
    end
    if (AWIDTH != $clog2(DEPTH)) begin : g_bad_awidth
      $error("param_lifo_stack: AWIDTH must equal ceil(log2(DEPTH))");
    end
  endgenerate

  logic [AWIDTH:0]       count_reg, count_next;
  logic [DWIDTH-1:0]     dout_reg, dout_next;
  logic                  dout_valid_reg, dout_valid_next;
  logic                  ovf_reg, ovf_next;
  logic                  udf_reg, udf_next;

  logic [AWIDTH-1:0]     wr_ptr;
  logic [AWIDTH-1:0]     top_idx;
  logic [AWIDTH-1:0]     wr_idx;
  logic                  wr_en;
  logic [DWIDTH-1:0]     top_data;
  logic [DEPTH*DWIDTH-1:0] entries_flat;

  // count <= DEPTH <= 2**AWIDTH, so modular AWIDTH-bit decrement yields count-1 whenever count>0
  assign wr_ptr  = count_reg[AWIDTH-1:0];
  assign top_idx = wr_ptr - AWIDTH'(1);

  assign empty = (count_reg == '0);
  assign full  = (count_reg == depth_c);

  // Storage: one register per entry, written only when its decoded index is selected
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DWIDTH-1:0] entry_reg;
      logic              entry_we;

      assign entry_we = wr_en && (wr_idx == AWIDTH'(gi));

      always_ff @(posedge clk) begin
        if (entry_we) begin
          entry_reg <= din;
        end
      end

      assign entries_flat[gi*DWIDTH +: DWIDTH] = entry_reg;
    end
  endgenerate

  always_comb begin
    top_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (top_idx == AWIDTH'(i)) begin
        top_data = entries_flat[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign top = empty ? '0 : top_data;

  // Error clear is applied first so that a same-cycle error event overrides it
  always_comb begin
    count_next      = count_reg;
    dout_next       = dout_reg;
    dout_valid_next = 1'b0;
    ovf_next        = ovf_reg;
    udf_next        = udf_reg;
    wr_en           = 1'b0;
    wr_idx          = wr_ptr;

    if (clr_err) begin
      ovf_next = 1'b0;
      udf_next = 1'b0;
    end

    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en      = 1'b1;
          count_next = count_reg + CW'(1);
        end else begin
          ovf_next = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          dout_next       = top_data;
          dout_valid_next = 1'b1;
          count_next      = count_reg - CW'(1);
        end else begin
          udf_next = 1'b1;
        end
      end
      2'b11: begin
        dout_valid_next = 1'b1;
        if (!empty) begin
          dout_next = top_data;
          wr_en     = 1'b1;
          wr_idx    = top_idx;
        end else begin
          dout_next = din;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg      <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      ovf_reg        <= 1'b0;
      udf_reg        <= 1'b0;
    end else begin
      count_reg      <= count_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      ovf_reg        <= ovf_next;
      udf_reg        <= udf_next;
    end
  end

  assign count      = count_reg;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign ovf        = ovf_reg;
  assign udf        = udf_reg;

endmodule

// File: tb/tb_param_lifo_stack.sv
// Bench for param_lifo_stack: 8x8 instance driven from a vector table, 16x6 instance
// driven by a stack model; popped data checked through scoreboard queues.
module tb_param_lifo_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        push_a = 0, pop_a = 0, clr_a = 0;
  logic [7:0]  din_a = '0;
  logic [7:0]  dout_a, top_a;
  logic        dv_a, empty_a, full_a, ovf_a, udf_a;
  logic [3:0]  count_a;

  logic        push_b = 0, pop_b = 0, clr_b = 0;
  logic [15:0] din_b = '0;
  logic [15:0] dout_b, top_b;
  logic        dv_b, empty_b, full_b, ovf_b, udf_b;
  logic [3:0]  count_b;

  int tests = 0;
  int failed = 0;

  logic [7:0]  sb_a[$];
  logic [15:0] sb_b[$];
  logic [15:0] model_b[$];

  always #5 clk = ~clk;

  param_lifo_stack #(.DWIDTH(8), .DEPTH(8), .AWIDTH(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .push(push_a), .pop(pop_a), .din(din_a), .clr_err(clr_a),
    .dout(dout_a), .dout_valid(dv_a), .top(top_a), .count(count_a),
    .empty(empty_a), .full(full_a), .ovf(ovf_a), .udf(udf_a)
  );

  param_lifo_stack #(.DWIDTH(16), .DEPTH(6), .AWIDTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .push(push_b), .pop(pop_b), .din(din_b), .clr_err(clr_b),
    .dout(dout_b), .dout_valid(dv_b), .top(top_b), .count(count_b),
    .empty(empty_b), .full(full_b), .ovf(ovf_b), .udf(udf_b)
  );

  typedef struct {
    logic       push, pop, clr;
    logic [7:0] din;
    int         cnt;
    logic [7:0] top;
    logic       dv;
    logic [7:0] dout;
    logic       ovf, udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic p, logic q, logic c, logic [7:0] d, int cnt,
                              logic [7:0] t, logic dv, logic [7:0] o, logic ov, logic ud);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.din = d; v.cnt = cnt;
    v.top = t; v.dv = dv; v.dout = o; v.ovf = ov; v.udf = ud;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic p, input logic q, input logic c, input logic [7:0] d);
    @(negedge clk);
    push_a = p; pop_a = q; clr_a = c; din_a = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic p, input logic q, input logic c, input logic [15:0] d);
    @(negedge clk);
    push_b = p; pop_b = q; clr_b = c; din_b = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check_a(input string name);
    if (dv_a) begin
      if (sb_a.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL %s: dout_valid with dout=0x%0h, expected no pop data", name, dout_a);
      end else begin
        chk(name, {24'h0, dout_a}, {24'h0, sb_a.pop_front()});
      end
    end
  endtask

  task automatic sb_check_b(input string name);
    if (dv_b) begin
      if (sb_b.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL %s: dout_valid with dout=0x%0h, expected no pop data", name, dout_b);
      end else begin
        chk(name, {16'h0, dout_b}, {16'h0, sb_b.pop_front()});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk("rst.count_a", count_a, 0);
    chk("rst.empty_a", empty_a, 1);
    chk("rst.full_a", full_a, 0);
    chk("rst.top_a", top_a, 0);
    chk("rst.dout_a", dout_a, 0);
    chk("rst.dv_a", dv_a, 0);
    chk("rst.ovf_a", ovf_a, 0);
    chk("rst.udf_a", udf_a, 0);
    chk("rst.count_b", count_b, 0);
    chk("rst.empty_b", empty_b, 1);
    rst_n = 1'b1;

    // ---------------- table-driven vectors, 8x8 instance ----------------
    vecs.push_back(mk(1,0,0,8'h11, 1,8'h11, 0,8'h00, 0,0));
    vecs.push_back(mk(1,0,0,8'h22, 2,8'h22, 0,8'h00, 0,0));
    vecs.push_back(mk(1,0,0,8'h33, 3,8'h33, 0,8'h00, 0,0));
    vecs.push_back(mk(0,1,0,8'h00, 2,8'h22, 1,8'h33, 0,0));
    vecs.push_back(mk(0,1,0,8'h00, 1,8'h11, 1,8'h22, 0,0));
    vecs.push_back(mk(0,1,0,8'h00, 0,8'h00, 1,8'h11, 0,0));
    vecs.push_back(mk(0,1,0,8'h00, 0,8'h00, 0,8'h11, 0,1));
    vecs.push_back(mk(0,0,1,8'h00, 0,8'h00, 0,8'h11, 0,0));
    vecs.push_back(mk(0,1,1,8'h00, 0,8'h00, 0,8'h11, 0,1));
    vecs.push_back(mk(0,0,1,8'h00, 0,8'h00, 0,8'h11, 0,0));
    vecs.push_back(mk(1,0,0,8'h5A, 1,8'h5A, 0,8'h11, 0,0));
    vecs.push_back(mk(1,1,0,8'hC3, 1,8'hC3, 1,8'h5A, 0,0));
    vecs.push_back(mk(0,1,0,8'h00, 0,8'h00, 1,8'hC3, 0,0));
    vecs.push_back(mk(1,1,0,8'h99, 0,8'h00, 1,8'h99, 0,0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,0,0,8'(i), i+1,8'(i), 0,8'h99, 0,0));
    vecs.push_back(mk(1,0,0,8'hAA, 8,8'h07, 0,8'h99, 1,0));
    vecs.push_back(mk(0,1,0,8'h00, 7,8'h06, 1,8'h07, 1,0));
    vecs.push_back(mk(0,0,1,8'h00, 7,8'h06, 0,8'h07, 0,0));
    vecs.push_back(mk(1,0,0,8'h08, 8,8'h08, 0,8'h07, 0,0));
    vecs.push_back(mk(1,1,0,8'h44, 8,8'h44, 1,8'h08, 0,0));
    vecs.push_back(mk(1,0,1,8'h55, 8,8'h44, 0,8'h08, 1,0));
    vecs.push_back(mk(0,0,0,8'h00, 8,8'h44, 0,8'h08, 1,0));

    foreach (vecs[i]) begin
      if (vecs[i].dv) sb_a.push_back(vecs[i].dout);
      step_a(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
      $display("[TB] vec %0d push=%0d pop=%0d clr=%0d din=%02h -> count=%0d top=%02h dv=%0d dout=%02h ovf=%0d udf=%0d",
               i, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din,
               count_a, top_a, dv_a, dout_a, ovf_a, udf_a);
      sb_check_a($sformatf("v%0d.sb_dout", i));
      chk($sformatf("v%0d.count", i), count_a, vecs[i].cnt);
      chk($sformatf("v%0d.top", i), top_a, vecs[i].top);
      chk($sformatf("v%0d.dv", i), dv_a, vecs[i].dv);
      chk($sformatf("v%0d.dout", i), dout_a, vecs[i].dout);
      chk($sformatf("v%0d.ovf", i), ovf_a, vecs[i].ovf);
      chk($sformatf("v%0d.udf", i), udf_a, vecs[i].udf);
      chk($sformatf("v%0d.empty", i), empty_a, vecs[i].cnt == 0);
      chk($sformatf("v%0d.full", i), full_a, vecs[i].cnt == 8);
    end
    chk("table.sb_drained", sb_a.size(), 0);

    // ---------------- asynchronous reset while full with ovf set ----------------
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("[TB] async reset from full: count=%0d dout=%02h ovf=%0d", count_a, dout_a, ovf_a);
    chk("arst1.count", count_a, 0);
    chk("arst1.empty", empty_a, 1);
    chk("arst1.dout", dout_a, 0);
    chk("arst1.ovf", ovf_a, 0);
    chk("arst1.top", top_a, 0);
    #1 rst_n = 1'b1;

    // four pushes, then reset between edges
    for (int i = 0; i < 4; i++) begin
      step_a(1, 0, 0, 8'h21 + 8'(i));
      $display("[TB] push %02h -> count=%0d top=%02h", 8'h21 + 8'(i), count_a, top_a);
    end
    chk("pre_rst.count", count_a, 4);
    sb_a.push_back(8'h24);
    step_a(0, 1, 0, 8'h00);
    sb_check_a("pre_rst.sb_dout");
    step_a(1, 0, 0, 8'h25);
    step_a(0, 0, 0, 8'h00);
    chk("pre_rst.count2", count_a, 4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-op: count=%0d empty=%0d dout=%02h dv=%0d", count_a, empty_a, dout_a, dv_a);
    chk("arst2.count", count_a, 0);
    chk("arst2.empty", empty_a, 1);
    chk("arst2.dout", dout_a, 0);
    chk("arst2.dv", dv_a, 0);
    #1 rst_n = 1'b1;

    step_a(1, 0, 0, 8'h77);
    $display("[TB] push 77 after reset -> count=%0d top=%02h", count_a, top_a);
    chk("post_rst.top", top_a, 8'h77);
    chk("post_rst.count", count_a, 1);
    sb_a.push_back(8'h77);
    step_a(0, 1, 0, 8'h00);
    $display("[TB] pop -> dv=%0d dout=%02h", dv_a, dout_a);
    chk("post_rst.dv", dv_a, 1);
    sb_check_a("post_rst.sb_dout");
    step_a(0, 0, 0, 8'h00);
    chk("post_rst.dv_drop", dv_a, 0);
    chk("post_rst.empty", empty_a, 1);

    // ---------------- 16x6 instance: fill, overflow, drain ----------------
    for (int i = 0; i < 6; i++) begin
      logic [15:0] d;
      d = 16'h1000 + 16'(i) * 16'h0111;
      step_b(1, 0, 0, d);
      model_b.push_back(d);
      $display("[TB] B push %04h -> count=%0d top=%04h full=%0d", d, count_b, top_b, full_b);
      chk($sformatf("b_push%0d.count", i), count_b, model_b.size());
      chk($sformatf("b_push%0d.top", i), top_b, d);
      chk($sformatf("b_push%0d.full", i), full_b, i == 5);
    end
    step_b(1, 0, 0, 16'hBEEF);
    $display("[TB] B push beef while full -> count=%0d ovf=%0d top=%04h", count_b, ovf_b, top_b);
    chk("b_ovf.ovf", ovf_b, 1);
    chk("b_ovf.count", count_b, 6);
    chk("b_ovf.top", top_b, model_b[model_b.size()-1]);

    for (int i = 0; i < 6; i++) begin
      sb_b.push_back(model_b.pop_back());
      step_b(0, 1, 0, 16'h0000);
      $display("[TB] B pop -> dv=%0d dout=%04h count=%0d", dv_b, dout_b, count_b);
      chk($sformatf("b_pop%0d.dv", i), dv_b, 1);
      sb_check_b($sformatf("b_pop%0d.sb_dout", i));
      chk($sformatf("b_pop%0d.count", i), count_b, model_b.size());
      chk($sformatf("b_pop%0d.top", i), top_b,
          (model_b.size() > 0) ? model_b[model_b.size()-1] : 16'h0000);
    end
    step_b(0, 0, 0, 16'h0000);
    chk("b_end.dv", dv_b, 0);
    chk("b_end.empty", empty_b, 1);
    chk("b_end.udf", udf_b, 0);
    chk("b_end.sb_drained", sb_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
